// File: rtl/nsa_pkg.sv
// nsa_pkg: shared slice width, FSM state type and slice-count helper for nibble_serial_adder
package nsa_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// ripple_carry_adder_4bit: 4-bit ripple-carry adder slice
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder processed one 4-bit slice per cycle; SIGNED_OVF_EN adds out_ovf
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef SIGNED_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int NSLICE = slice_count(WIDTH);
    localparam int IW = $clog2(NSLICE);
    if (WIDTH % SLICE_W != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end
    nsa_state_t state, state_n;
    logic [IW-1:0] idx;
    logic [IW+1:0] base;
    logic [WIDTH-1:0] a, b;
    logic carry, last, s_cout;
    logic [SLICE_W-1:0] s_sum;
    assign base = {idx, 2'b00};
    assign last = idx == IW'(NSLICE - 1);
    ripple_carry_adder_4bit u_slice (
        .a    (a[base +: SLICE_W]),
        .b    (b[base +: SLICE_W]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // next state and handshake outputs; reset forces all handshakes low
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && in_valid) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
        in_ready  = !rst && state == IDLE;
        out_valid = !rst && state == DONE;
        busy      = !rst && state != IDLE;
    end
    // operand latch, slice sequencing, carry chaining and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a        <= '0;
            b        <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a     <= in_a;
            b     <= in_b;
            carry <= in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            out_sum[base +: SLICE_W] <= s_sum;
            carry <= s_cout;
            idx   <= last ? idx : idx + 1'b1;
            if (last) out_cout <= s_cout;
        end
    end
`ifdef SIGNED_OVF_EN
    // signed overflow, captured alongside the final slice
    always_ff @(posedge clk) begin
        if (rst) out_ovf <= 1'b0;
        else if (state == RUN && last) out_ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (s_sum[SLICE_W-1] != a[WIDTH-1]);
    end
`endif
endmodule
